// File: rtl/pipe_cla_addsub.sv
// pipe_cla_addsub
//   Pipelined carry look-ahead adder/subtractor. A DW-bit add is cut into
//   STAGES segments of DW/STAGES bits; each pipeline stage resolves one
//   segment with chained 4-bit CLA blocks and hands its carry to the next
//   stage through a register. Unconsumed upper operand bits travel with the
//   transaction, and finished low segments accumulate so the result leaves
//   the last stage already aligned. Latency is STAGES cycles with no stall.
//
// Ports
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset
//   valid_i  input transaction valid
//   ready_o  block can accept an input this cycle
//   a_i      operand A (DW bits)
//   b_i      operand B (DW bits)
//   ci_i     carry-in (borrow-in when sub_i=1)
//   sub_i    0: s = a+b+ci, 1: s = a-b-ci
//   valid_o  result valid
//   ready_i  downstream accepts result
//   s_o      sum/difference (DW bits)
//   c_o      carry-out of MSB (sub mode: 1 = no borrow)
//   ov_o     two's-complement signed overflow
module pipe_cla_addsub #(
    parameter int DW     = 32,
    parameter int STAGES = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          ci_i,
    input  logic          sub_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] s_o,
    output logic          c_o,
    output logic          ov_o
);

    localparam int          SEG  = (STAGES > 0) ? DW / STAGES : 4;
    localparam int unsigned NBLK = SEG / 4;

    if ((STAGES < 1) || (DW % (4 * STAGES) != 0)) begin : g_param_check
        $fatal(1, "pipe_cla_addsub: DW must be a multiple of 4*STAGES and STAGES >= 1");
    end

    // 4-bit look-ahead block: p = a|b, g = a&b. Returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = a | b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], a ^ b ^ c[3:0]};
    endfunction

    logic [DW-1:0] b_eff;
    logic          cin0;
    logic [STAGES:1] adv;   // adv[k]: stage k takes the contents of stage k-1

    assign b_eff         = sub_i ? ~b_i : b_i;
    assign cin0          = sub_i ? ~ci_i : ci_i;
    assign adv[STAGES]   = ready_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Stage k only sees the operand bits it has not consumed yet.
        localparam int SW = DW - k * SEG;

        logic [SW-1:0]          src_a;
        logic [SW-1:0]          src_b;
        logic                   src_c;
        logic                   src_v;
        logic [(k+1)*SEG-1:0]   s_next;
        logic [SEG-1:0]         seg_s;
        logic                   seg_c;
        logic [4:0]             blk;
        logic                   ld;
        logic                   v_q;
        logic                   c_q;
        logic [(k+1)*SEG-1:0]   s_q;

        if (k == 0) begin : g_src
            assign src_a  = a_i;
            assign src_b  = b_eff;
            assign src_c  = cin0;
            assign src_v  = valid_i;
            assign s_next = seg_s;
        end else begin : g_src
            assign src_a  = g_stage[k-1].g_fwd.a_q;
            assign src_b  = g_stage[k-1].g_fwd.b_q;
            assign src_c  = g_stage[k-1].c_q;
            assign src_v  = g_stage[k-1].v_q;
            assign s_next = {seg_s, g_stage[k-1].s_q};
            assign adv[k] = ld;
        end

        always_comb begin
            seg_c = src_c;
            seg_s = '0;
            blk   = '0;
            for (int unsigned j = 0; j < NBLK; j++) begin
                blk             = cla4(src_a[4*j +: 4], src_b[4*j +: 4], seg_c);
                seg_s[4*j +: 4] = blk[3:0];
                seg_c           = blk[4];
            end
        end

        // Empty stages load regardless of downstream, so bubbles collapse.
        assign ld = src_v & (~v_q | adv[k+1]);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (ld) begin
                v_q <= 1'b1;
                c_q <= seg_c;
                s_q <= s_next;
            end else if (adv[k+1]) begin
                v_q <= 1'b0;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [SW-SEG-1:0] a_q;
            logic [SW-SEG-1:0] b_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (ld) begin
                    a_q <= src_a[SW-1:SEG];
                    b_q <= src_b[SW-1:SEG];
                end
            end
        end else begin : g_last
            logic ov_q;
            logic ov_next;

            // Carry into the MSB is recovered as a^b^sum at that bit.
            assign ov_next = src_a[SEG-1] ^ src_b[SEG-1] ^ seg_s[SEG-1] ^ seg_c;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    ov_q <= 1'b0;
                end else if (ld) begin
                    ov_q <= ov_next;
                end
            end
        end
    end

    assign ready_o = ~g_stage[0].v_q | adv[1];
    assign valid_o = g_stage[STAGES-1].v_q;
    assign s_o     = g_stage[STAGES-1].s_q;
    assign c_o     = g_stage[STAGES-1].c_q;
    assign ov_o    = g_stage[STAGES-1].g_last.ov_q;

endmodule

// File: doc/pipe_cla_addsub.md
Name: pipe_cla_addsub

Overview:
- Parametrised, pipelined carry look-ahead adder/subtractor. Successor to the team's combinational 4-bit-block CLA.
- Splits a DW-bit add into STAGES segments, one segment resolved per pipeline stage. Carry travels between stages in registers; operands are skewed in and results de-skewed out.
- Adds carry-in, a subtract mode, signed-overflow output and valid/ready flow control.
- Sits in datapaths where a full-width combinational CLA misses timing.

Parameters:
- DW, 32, operand and result width; must be a multiple of 4*STAGES.
- STAGES, 2, number of pipeline stages and the latency in cycles; must be 1 or more.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  input transaction valid.
- ready_o  output  1  block can accept an input this cycle.
- a_i  input  DW  operand A.
- b_i  input  DW  operand B.
- ci_i  input  1  carry-in (borrow-in when sub_i=1).
- sub_i  input  1  0: s = a+b+ci; 1: s = a-b-ci.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- s_o  output  DW  sum/difference.
- c_o  output  1  carry-out of MSB; in sub mode 1 = no borrow.
- ov_o  output  1  two's-complement signed overflow.

Behaviour:
- Segment width SEG = DW/STAGES. Each segment is built from SEG/4 chained 4-bit CLA blocks (p = a|b, g = a&b, full look-ahead inside each block), so it matches the existing block.
- Operand conditioning happens at capture:
  - beff = sub_i ? ~b_i : b_i
  - cin0 = sub_i ? ~ci_i : ci_i
- Stage k (0..STAGES-1) adds segment k of a and beff using the carry registered by stage k-1 (cin0 for k=0).
  - Computed segment results are stored in the stage's result register.
  - Not-yet-added upper segments of a/beff are carried forward in that stage's registers.
- Final stage produces the following, registered in the output stage:
  - c_o = carry out of bit DW-1
  - ov_o = carry into bit DW-1 XOR carry out of bit DW-1
- Latency: exactly STAGES cycles from an accepted input (valid_i & ready_o at edge) to valid_o, when ready_i is held 1. Throughput is 1 per cycle.
- Occupancy: per-stage valid bit v[k]. valid_o = v[STAGES-1].
- Advance rules:
  - adv[STAGES] = ready_i
  - stage k loads when its source is valid (valid_i for k=0, v[k-1] otherwise) and (~v[k] | adv[k+1])
  - ready_o = ~v[0] | adv[1]
- Bubbles collapse: an empty stage loads even while downstream stalls.
- Stall: while valid_o=1 and ready_i=0, s_o/c_o/ov_o/valid_o hold stable. No transaction is dropped, duplicated or reordered.
- A stage that is not loading keeps its data. A stage emptied by advance with no new source clears v[k]; its data is don't-care.
- Same-cycle output accept and input accept in a full pipe is legal. Every stage shifts; no bubble is inserted.
- Reset (asynchronous, any time, including mid-transaction):
  - clears all v[k] immediately, so valid_o=0 with no clock edge
  - clears data registers to 0, so s_o=0, c_o=0, ov_o=0
  - ready_o=1 after reset
  - in-flight transactions are discarded; none reappear after release
- Inputs are sampled only on accept. a_i/b_i/ci_i/sub_i are don't-care when valid_i=0.
- STAGES=1: a fully combinational DW-bit add with a registered output and the same handshake; latency 1.
- Elaboration check: simulation-only fatal if DW % (4*STAGES) != 0 or STAGES < 1.

Test Plan:
- DW=16, STAGES=2, ready_i=1; a=0x00FF, b=0x0001, ci=0, sub=0 -> 2 cycles later s=0x0100, c=0, ov=0 (carry crosses the stage boundary).
- a=0xFFFF, b=0x0001, add -> s=0x0000, c=1, ov=0.
- a=0x7FFF, b=0x0001, add -> s=0x8000, c=0, ov=1.
- a=0xFFFF, b=0xFFFF, ci=1, add -> s=0xFFFF, c=1, ov=0.
- Subtract cases (sub=1, ci=0):
  - a=0x0005, b=0x0007 -> s=0xFFFE, c=0, ov=0.
  - a=0x8000, b=0x0001 -> s=0x7FFF, c=1, ov=1.
  - a=0x0005, b=0x0003, ci=1 -> s=0x0001, c=1.
- Backpressure: 4 back-to-back inputs (1+1, 2+2, 3+3, 4+4), ready_i=0 for 3 cycles starting at the first valid_o. Required response:
  - ready_o drops when both stages are full
  - s_o stays 0x0002 throughout the stall
  - results 2, 4, 6, 8 come out in order, with no loss or duplicates
- Reset mid-flight: both stages valid, assert rst_i between edges -> valid_o=0 and s_o=0 immediately. After release, ready_o=1 and no stale result appears.
- Random: DW=32, STAGES=4 and DW=8, STAGES=1, random valid_i/ready_i, 10k transactions -> all fields match a scoreboard model and latency equals STAGES under no stall.
